unified_mem_arbiter: RTL
========================

# unified_mem_arbiter

Arbiter that shares one single-port synchronous unified RAM between the core's instruction-fetch port and its data (load/store) port. It sits between the core's IROM/DRAM interfaces and the RAM macro. Each cycle it grants at most one access, with data having priority. A deferred fetch is held in a pending register, and the block requests a front-end stall until that fetch is issued. It also supports a fetch-kill used on branch flush.

## Interface
- ADDR_WIDTH, 32, byte address width (both ports and RAM)
- DATA_WIDTH, 32, data word width
- MASK_WIDTH, 4, byte-lane write mask width

Ports:
- clk  in  1  core clock
- rst  in  1  asynchronous, active-low reset
- i_req  in  1  fetch request (irom_rd_en)
- i_addr  in  ADDR_WIDTH  fetch address
- i_kill  in  1  cancel pending and in-flight fetch (branch flush)
- i_rdata  out  DATA_WIDTH  fetched instruction, held between returns
- i_valid  out  1  i_rdata updated this cycle
- d_rd_en  in  1  load request
- d_wr_en  in  1  store request
- d_addr  in  ADDR_WIDTH  data address
- d_wdata  in  DATA_WIDTH  store data
- d_mask  in  MASK_WIDTH  store byte lanes
- d_rdata  out  DATA_WIDTH  load data
- d_valid  out  1  load data valid this cycle
- stall_req  out  1  hold PC and IF/ID; fetch not granted
- wait_cnt  out  4  saturating count of consecutive stalled cycles
- ram_en, ram_we  out  1  RAM access enable / write enable
- ram_addr  out  ADDR_WIDTH  RAM address
- ram_wdata  out  DATA_WIDTH  RAM write data
- ram_mask  out  MASK_WIDTH  RAM write byte lanes
- ram_rdata  in  DATA_WIDTH  RAM read data, valid one cycle after a read is enabled

## Operation
- Data request: d_rd_en | d_wr_en. If both are high, treat it as a store (ram_we=1) and flag no load return.
- Fetch source: pend_valid ? pend_addr : i_addr. Fetch active: pend_valid | i_req.
- Grant, combinational each cycle:
  - data request present → DATA grant;
  - otherwise, fetch active and !i_kill → INST grant;
  - otherwise NONE.
- RAM drive:
  - DATA grant: ram_addr=d_addr, ram_we=d_wr_en, ram_wdata=d_wdata, ram_mask=d_mask.
  - INST grant: ram_addr = fetch source, ram_we=0, ram_mask=0.
  - ram_en=1 on any grant.
- Pending register:
  - Set when i_req is high, the grant is DATA, and pend_valid=0; captures pend_addr=i_addr.
  - Cleared on INST grant or on i_kill.
  - A new i_req while pend_valid=1 does not overwrite pend_addr.
- Return tracker: the registered rtn field ∈ {NONE, INST, DLOAD} records the previous cycle's read grant. A store records NONE.
  - rtn=INST and no kill since issue → i_valid=1, i_rdata=ram_rdata, and i_hold ← ram_rdata.
  - rtn=INST and i_kill seen in the issue cycle or the return cycle → i_valid=0, i_hold unchanged.
  - rtn=DLOAD → d_valid=1, d_rdata=ram_rdata. Otherwise d_rdata holds its last value.
  - i_rdata = i_valid ? ram_rdata : i_hold.
- stall_req = fetch active & !i_kill & grant≠INST.
- wait_cnt: increments while stall_req=1 and saturates at 15. Cleared on any cycle with stall_req=0.

## Timing
- Grant and RAM drive are combinational from the same-cycle request. Read data returns exactly 1 cycle later.
- Load latency: request in cycle N → d_valid in cycle N+1. Store is complete at the cycle-N edge.
- Fetch latency:
  - uncontended: 1 cycle;
  - deferred: 1 + k cycles, where k is the number of consecutive data-request cycles.
- Data accesses are never delayed. Back-to-back data accesses starve fetch indefinitely, with stall_req high throughout.
- i_kill in the same cycle as an INST grant suppresses the grant (ram_en=0 unless there is data) and clears pend_valid.
- Reset values (async, rst=0):
  - rtn=NONE, pend_valid=0, pend_addr=0, i_hold=0, wait_cnt=0;
  - all outputs 0: i_rdata, d_rdata, i_valid, d_valid, stall_req, ram_en, ram_we, ram_addr, ram_wdata, ram_mask.
- Reset asserted mid-operation discards any pending or in-flight access. No valid is produced after release.

## Test plan
- Uncontended fetch: i_req=1, i_addr=0x100, ram_rdata=0x00500093 next cycle → ram_en=1/ram_we=0 at cycle N; i_valid=1, i_rdata=0x00500093 at N+1; stall_req=0 throughout.
- Conflict: i_req with i_addr=0x104 and d_rd_en with d_addr=0x2000 in cycle N.
  - Cycle N: ram_addr=0x2000, stall_req=1.
  - Cycle N+1: d_valid=1; ram_addr=0x104 from pend.
  - Cycle N+2: i_valid=1.
- Starvation: loads on 5 consecutive cycles with i_req held → stall_req=1 for 5 cycles, wait_cnt reaches 5, fetch issues in cycle 6. Extend to 20 cycles → wait_cnt saturates at 15.
- Kill: pending fetch 0x108 and i_kill pulsed → pend cleared, no INST grant. Separately, kill in the cycle after an INST issue → i_valid=0 and i_rdata keeps its previous value.
- Store, with both enables high: d_wr_en=1, d_rd_en=1, d_mask=4'b0011, d_wdata=0xDEADBEEF → ram_we=1, ram_mask=0011, d_valid=0 next cycle.
- Reset mid-fetch: rst=0 between issue and return → all outputs 0 immediately. After release, no i_valid or d_valid pulse occurs.

Source files
------------

// File: rtl/unified_mem_arbiter_if.sv
// Core-side and RAM-side bus of the unified memory arbiter.
// slave  : the arbiter's view; master : the core/RAM environment's view.
interface unified_mem_arbiter_if #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int MASK_WIDTH = 4
);
   // instruction-fetch port
   logic                  i_req;
   logic [ADDR_WIDTH-1:0] i_addr;
   logic                  i_kill;
   logic [DATA_WIDTH-1:0] i_rdata;
   logic                  i_valid;
   // data port
   logic                  d_rd_en;
   logic                  d_wr_en;
   logic [ADDR_WIDTH-1:0] d_addr;
   logic [DATA_WIDTH-1:0] d_wdata;
   logic [MASK_WIDTH-1:0] d_mask;
   logic [DATA_WIDTH-1:0] d_rdata;
   logic                  d_valid;
   // front-end stall
   logic                  stall_req;
   logic [3:0]            wait_cnt;
   // RAM macro
   logic                  ram_en;
   logic                  ram_we;
   logic [ADDR_WIDTH-1:0] ram_addr;
   logic [DATA_WIDTH-1:0] ram_wdata;
   logic [MASK_WIDTH-1:0] ram_mask;
   logic [DATA_WIDTH-1:0] ram_rdata;

   modport slave (
      input  i_req, i_addr, i_kill, d_rd_en, d_wr_en, d_addr, d_wdata, d_mask, ram_rdata,
      output i_rdata, i_valid, d_rdata, d_valid, stall_req, wait_cnt,
             ram_en, ram_we, ram_addr, ram_wdata, ram_mask
   );

   modport master (
      output i_req, i_addr, i_kill, d_rd_en, d_wr_en, d_addr, d_wdata, d_mask, ram_rdata,
      input  i_rdata, i_valid, d_rdata, d_valid, stall_req, wait_cnt,
             ram_en, ram_we, ram_addr, ram_wdata, ram_mask
   );
endinterface

// File: rtl/unified_mem_arbiter.sv
// Shares one single-port synchronous RAM between instruction fetch and
// load/store. Data always wins; a losing fetch is parked in a pending
// register and the front end is stalled until it issues.
module unified_mem_arbiter #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int MASK_WIDTH = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   unified_mem_arbiter_if.slave   bus
);

   typedef enum logic [1:0] {G_NONE, G_DATA, G_INST} grant_e;
   typedef enum logic [1:0] {R_NONE, R_INST, R_DLOAD} rtn_e;

   grant_e                grant;
   logic                  d_req;
   logic                  fetch_act;
   logic [ADDR_WIDTH-1:0] fetch_addr;

   logic                  pend_valid_q, pend_valid_d;
   logic [ADDR_WIDTH-1:0] pend_addr_q, pend_addr_d;
   rtn_e                  rtn_q, rtn_d;
   logic [DATA_WIDTH-1:0] i_hold_q, i_hold_d;
   logic [DATA_WIDTH-1:0] d_hold_q, d_hold_d;
   logic [3:0]            wait_cnt_q, wait_cnt_d;

   // Grant decision; reset forces NONE so the RAM sees no access while held.
   always_comb begin
      d_req      = bus.d_rd_en | bus.d_wr_en;
      fetch_act  = pend_valid_q | bus.i_req;
      fetch_addr = pend_valid_q ? pend_addr_q : bus.i_addr;
      grant      = G_NONE;
      if (!rst)                       grant = G_NONE;
      else if (d_req)                 grant = G_DATA;
      else if (fetch_act && !bus.i_kill) grant = G_INST;
   end

   // RAM drive from the winning requester; idle bus is all zero.
   always_comb begin
      bus.ram_en    = 1'b0;
      bus.ram_we    = 1'b0;
      bus.ram_addr  = '0;
      bus.ram_wdata = '0;
      bus.ram_mask  = '0;
      case (grant)
         G_DATA: begin
            bus.ram_en    = 1'b1;
            bus.ram_we    = bus.d_wr_en;
            bus.ram_addr  = bus.d_addr;
            bus.ram_wdata = bus.d_wdata;
            bus.ram_mask  = bus.d_mask;
         end
         G_INST: begin
            bus.ram_en    = 1'b1;
            bus.ram_addr  = fetch_addr;
         end
         default: ;
      endcase
   end

   // Return path and stall. A kill in the return cycle drops the fetched word;
   // a kill in the issue cycle already suppressed the grant itself.
   always_comb begin
      bus.i_valid   = (rtn_q == R_INST) && !bus.i_kill;
      bus.i_rdata   = bus.i_valid ? bus.ram_rdata : i_hold_q;
      bus.d_valid   = (rtn_q == R_DLOAD);
      bus.d_rdata   = bus.d_valid ? bus.ram_rdata : d_hold_q;
      bus.stall_req = rst && fetch_act && !bus.i_kill && (grant != G_INST);
      bus.wait_cnt  = wait_cnt_q;
   end

   // Next-state for pending fetch, return tracker, hold registers and stall counter.
   always_comb begin
      pend_valid_d = pend_valid_q;
      pend_addr_d  = pend_addr_q;
      if (grant == G_INST || bus.i_kill) begin
         pend_valid_d = 1'b0;
      end else if (bus.i_req && grant == G_DATA && !pend_valid_q) begin
         pend_valid_d = 1'b1;
         pend_addr_d  = bus.i_addr;
      end

      rtn_d = R_NONE;
      if (grant == G_INST)                                   rtn_d = R_INST;
      else if (grant == G_DATA && bus.d_rd_en && !bus.d_wr_en) rtn_d = R_DLOAD;

      i_hold_d   = bus.i_valid ? bus.ram_rdata : i_hold_q;
      d_hold_d   = bus.d_valid ? bus.ram_rdata : d_hold_q;

      wait_cnt_d = 4'd0;
      if (bus.stall_req) wait_cnt_d = (wait_cnt_q == 4'd15) ? 4'd15 : wait_cnt_q + 4'd1;
   end

   // State registers; async reset discards any pending or in-flight access.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pend_valid_q <= 1'b0;
         pend_addr_q  <= '0;
         rtn_q        <= R_NONE;
         i_hold_q     <= '0;
         d_hold_q     <= '0;
         wait_cnt_q   <= 4'd0;
      end else begin
         pend_valid_q <= pend_valid_d;
         pend_addr_q  <= pend_addr_d;
         rtn_q        <= rtn_d;
         i_hold_q     <= i_hold_d;
         d_hold_q     <= d_hold_d;
         wait_cnt_q   <= wait_cnt_d;
      end
   end

endmodule
